tdm_mux_16_1: RTL



---
 rtl/tdm_mux_16_1.sv | 83 ++++++++
 1 files changed

// File: rtl/tdm_mux_16_1.sv
// 16:1 round-robin time-division multiplexer: one registered output word per
// cycle, tagged with its source channel, valid/ready on the output side.
module tdm_mux_16_1 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  input  logic                     Enable_In,
  input  logic [16*DATA_WIDTH-1:0] Data_In,
  input  logic [15:0]              Valid_In,
  output logic [15:0]              Ready_Out,
  output logic [DATA_WIDTH-1:0]    Data_Out,
  output logic [3:0]               Select_Out,
  output logic                     Valid_Out,
  input  logic                     Ready_In
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state, state_next;
  logic [3:0]            ptr;
  logic [3:0]            grant;
  logic [3:0]            idx;
  logic                  found;
  logic                  cap;
  logic [DATA_WIDTH-1:0] words [16];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      words[i] = Data_In[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search upward from the slot after the last grant; 4-bit add wraps 15 -> 0.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = ptr + 4'(i + 1);
      if (!found && Valid_In[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    cap       = Enable_In && found && (state == EMPTY || Ready_In) && !Reset_In;
    Ready_Out = '0;
    if (cap) begin
      Ready_Out[grant] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (cap) state_next = FULL;
      FULL:    if (Ready_In && !cap) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state      <= EMPTY;
      ptr        <= 4'hF;
      Data_Out   <= '0;
      Select_Out <= '0;
    end else begin
      state <= state_next;
      if (cap) begin
        ptr        <= grant;
        Data_Out   <= words[grant];
        Select_Out <= grant;
      end
    end
  end

  always_comb Valid_Out = (state == FULL);

endmodule
